// File: rtl/loop_seq_ctrl_pkg.sv
// Shared definitions for the two-level loop sequencer.
//   state_e       : FSM state encoding (idle / run / finish)
//   LOOP_OUTER_W  : default outer index width
//   LOOP_INNER_W  : default inner index width
package loop_seq_ctrl_pkg;

    localparam int unsigned LOOP_OUTER_W = 8;
    localparam int unsigned LOOP_INNER_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

endpackage

// File: rtl/loop_wrap_cnt.sv
// Wrapping index counter used for each loop level.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (takes priority over inc)
//   inc        : advance; wraps to 0 when already at the bound
//   last       : inclusive bound
//   cnt        : current count (registered)
//   at_last    : cnt == last (decoded from the register)
module loop_wrap_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         at_last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Equality compare means the count never runs past the bound, so no carry bit is needed.
    assign at_last = (cnt_q == last);
    assign cnt     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/loop_seq_ctrl.sv
// Two-level loop sequencer. On start it walks every (outer, inner) index pair from (0,0) to
// the latched bounds, inner index fastest, presenting each pair under a valid/ready handshake.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : begin a sequence (accepted only when idle)
//   abort                  : synchronous cancel back to idle, no done
//   outer_last, inner_last : inclusive bounds, latched on an accepted start
//   step_ready             : downstream accepts the current pair
//   step_valid             : current pair is valid
//   outer_idx, inner_idx   : current pair
//   inner_first            : inner_idx == 0 while step_valid
//   inner_end              : inner_idx at its latched bound while step_valid
//   busy                   : sequence running
//   done                   : one-cycle pulse after the final pair is accepted
module loop_seq_ctrl
    import loop_seq_ctrl_pkg::*;
#(
    parameter int unsigned OUTER_WIDTH = LOOP_OUTER_W,
    parameter int unsigned INNER_WIDTH = LOOP_INNER_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [OUTER_WIDTH-1:0] outer_last,
    input  logic [INNER_WIDTH-1:0] inner_last,
    input  logic                   step_ready,
    output logic                   step_valid,
    output logic [OUTER_WIDTH-1:0] outer_idx,
    output logic [INNER_WIDTH-1:0] inner_idx,
    output logic                   inner_first,
    output logic                   inner_end,
    output logic                   busy,
    output logic                   done
);

    state_e                 state_q;
    logic [OUTER_WIDTH-1:0] outer_last_q;
    logic [INNER_WIDTH-1:0] inner_last_q;
    logic                   step_valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic fire;
    logic start_acc;
    logic inner_at_last;
    logic outer_at_last;
    logic final_step;
    logic inner_inc;
    logic outer_inc;

    // step_valid is only ever high in RUN, so fire implies RUN.
    assign fire       = step_valid_q && step_ready;
    assign start_acc  = (state_q == StIdle) && start && !abort;
    assign final_step = inner_at_last && outer_at_last;

    // The final pair must not wrap: indices hold their last values until the next start.
    // An aborted fire counts as delivered but does not advance the indices.
    assign inner_inc = fire && !abort && !final_step;
    assign outer_inc = fire && !abort && inner_at_last && !outer_at_last;

    loop_wrap_cnt #(
        .W (INNER_WIDTH)
    ) u_inner_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc),
        .inc     (inner_inc),
        .last    (inner_last_q),
        .cnt     (inner_idx),
        .at_last (inner_at_last)
    );

    loop_wrap_cnt #(
        .W (OUTER_WIDTH)
    ) u_outer_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_acc),
        .inc     (outer_inc),
        .last    (outer_last_q),
        .cnt     (outer_idx),
        .at_last (outer_at_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            outer_last_q <= '0;
            inner_last_q <= '0;
            step_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_acc) begin
                        outer_last_q <= outer_last;
                        inner_last_q <= inner_last;
                        state_q      <= StRun;
                        step_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q      <= StIdle;
                        step_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b0;
                    end else if (fire && final_step) begin
                        state_q      <= StFin;
                        step_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                StFin: begin
                    // Leaving FIN always ends the done pulse; abort here changes nothing else.
                    state_q      <= StIdle;
                    step_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
                default: begin
                    state_q      <= StIdle;
                    step_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign step_valid  = step_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign inner_first = step_valid_q && (inner_idx == '0);
    assign inner_end   = step_valid_q && inner_at_last;

endmodule
